// File: rtl/id_stage_pipe_pkg.sv
// id_pkg: opcode constants, instruction field layout and immediate sign extension for the ID stage.
package id_pkg;
    localparam logic [3:0] OP_R   = 4'b0000;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b0110;
    localparam int IMM_MSB = 5;
    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic [2:0] funct;
    } instr_t;
    function automatic logic [63:0] sign_ext6(input logic [IMM_MSB:0] imm);
        return {{(63-IMM_MSB){imm[IMM_MSB]}}, imm};
    endfunction
endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF-side handshake, write-back port and ID/EX outputs of the decode stage.
interface id_stage_pipe_if #(parameter int DATA_W = 16, parameter int REG_ADDR_W = 3);
    logic                  if_valid;
    logic [15:0]           instruction;
    logic                  if_ready;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  ex_ready;
    logic                  id_valid;
    logic [3:0]            id_opcode;
    logic [2:0]            id_funct;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic [DATA_W-1:0]     id_rs_data;
    logic [DATA_W-1:0]     id_rt_data;
    logic [DATA_W-1:0]     id_imm;
    logic                  id_is_load;
    logic                  hazard_stall;
    modport slave (
        input  if_valid, instruction, wb_we, wb_addr, wb_data, ex_ready,
        output if_ready, id_valid, id_opcode, id_funct, id_rs_addr, id_rt_addr, id_rd_addr,
               id_rs_data, id_rt_data, id_imm, id_is_load, hazard_stall
    );
    modport master (
        output if_valid, instruction, wb_we, wb_addr, wb_data, ex_ready,
        input  if_ready, id_valid, id_opcode, id_funct, id_rs_addr, id_rt_addr, id_rd_addr,
               id_rs_data, id_rt_data, id_imm, id_is_load, hazard_stall
    );
endinterface

// File: rtl/id_stage_pipe_regfile_bypass.sv
// regfile_bypass: 2-read/1-write register file with write-through bypass and optional hardwired-zero R0.
module regfile_bypass #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr_a,
    input  logic [REG_ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0]     o_rdata_a,
    output logic [DATA_W-1:0]     o_rdata_b
);
    localparam int NUM_REGS = 2**REG_ADDR_W;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_we_ok;
    assign w_we_ok = i_we && !(ZERO_REG && i_waddr == '0);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_regs <= '{default: '0};
        else if (w_we_ok) r_regs[i_waddr] <= i_wdata;
    end
    assign o_rdata_a = (w_we_ok && i_waddr == i_raddr_a) ? i_wdata :
                       (ZERO_REG && i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (w_we_ok && i_waddr == i_raddr_b) ? i_wdata :
                       (ZERO_REG && i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with register file, ID/EX pipeline register, valid/ready flow control
// and one-bubble load-use hazard insertion.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter bit ZERO_REG   = 1'b1
) (
    input logic          i_clock,
    input logic          i_reset_n,
    id_stage_pipe_if.slave bus
);
    instr_t                w_ins;
    logic [REG_ADDR_W-1:0] w_rs, w_rt, w_rd, w_dst;
    logic [DATA_W-1:0]     w_rs_data, w_rt_data;
    logic                  w_reads_rt, w_hazard, w_adv, w_load, w_wb_ok;
    logic                  r_valid, r_is_load;
    logic [3:0]            r_opcode;
    logic [2:0]            r_funct;
    logic [REG_ADDR_W-1:0] r_rs_addr, r_rt_addr, r_rd_addr;
    logic [DATA_W-1:0]     r_rs_data, r_rt_data, r_imm;
    assign w_ins = instr_t'(bus.instruction);
    assign w_rs  = REG_ADDR_W'(w_ins.rs);
    assign w_rt  = REG_ADDR_W'(w_ins.rt);
    assign w_rd  = REG_ADDR_W'(w_ins.rd);
    assign w_dst = (w_ins.opcode == OP_R) ? w_rd : w_rt;
    assign w_reads_rt = (w_ins.opcode == OP_R) || (w_ins.opcode == OP_SW) || (w_ins.opcode == OP_BEQ);
    // A load in ID/EX blocks any consumer of its destination; the bubble it causes clears r_valid
    assign w_hazard = r_valid && r_is_load && (r_rd_addr != '0 || !ZERO_REG) &&
                      (w_rs == r_rd_addr || (w_reads_rt && w_rt == r_rd_addr)) && bus.if_valid;
    assign w_adv   = !r_valid || bus.ex_ready;
    assign w_load  = w_adv && bus.if_valid && !w_hazard;
    assign w_wb_ok = bus.wb_we && !(ZERO_REG && bus.wb_addr == '0);
    regfile_bypass #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_rf (
        .i_clk     (i_clock),
        .i_rst_n   (i_reset_n),
        .i_we      (bus.wb_we),
        .i_waddr   (bus.wb_addr),
        .i_wdata   (bus.wb_data),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rs_data),
        .o_rdata_b (w_rt_data)
    );
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid   <= 1'b0;
            r_is_load <= 1'b0;
            r_opcode  <= '0;
            r_funct   <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_rd_addr <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
        end else if (w_adv) begin
            r_valid <= w_load;
            if (w_load) begin
                r_is_load <= (w_ins.opcode == OP_LW);
                r_opcode  <= w_ins.opcode;
                r_funct   <= w_ins.funct;
                r_rs_addr <= w_rs;
                r_rt_addr <= w_rt;
                r_rd_addr <= w_dst;
                r_rs_data <= w_rs_data;
                r_rt_data <= w_rt_data;
                r_imm     <= DATA_W'(sign_ext6(bus.instruction[IMM_MSB:0]));
            end
        end else begin
            // Held operands track write-back so EX never consumes a stale value
            if (w_wb_ok && bus.wb_addr == r_rs_addr) r_rs_data <= bus.wb_data;
            if (w_wb_ok && bus.wb_addr == r_rt_addr) r_rt_data <= bus.wb_data;
        end
    end
    assign bus.if_ready     = w_adv && !w_hazard;
    assign bus.hazard_stall = w_adv && w_hazard;
    assign bus.id_valid     = r_valid;
    assign bus.id_is_load   = r_is_load;
    assign bus.id_opcode    = r_opcode;
    assign bus.id_funct     = r_funct;
    assign bus.id_rs_addr   = r_rs_addr;
    assign bus.id_rt_addr   = r_rt_addr;
    assign bus.id_rd_addr   = r_rd_addr;
    assign bus.id_rs_data   = r_rs_data;
    assign bus.id_rt_data   = r_rt_data;
    assign bus.id_imm       = r_imm;
endmodule
